led_matrix_scanner: RTL

Row-multiplexing driver for the 8x8 LED matrix, directly downstream of the game logic's flat LED image. It double-buffers the 64-bit image behind a valid/ready handshake, swaps buffers only at frame boundaries so no frame tears, and scans one row at a time onto the row cathodes and column anodes. It also blinks one selectable LED, used for the snake head in the game-over state.

---
 rtl/snake_pkg.sv | 32 +++
 rtl/led_matrix_scanner_if.sv | 22 ++
 rtl/led_matrix_scanner_scan_timer.sv | 72 +++++++
 rtl/led_matrix_scanner.sv | 83 ++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game's LED matrix path.
// Image bit 8*r+c is row r, column c.
package snake_pkg;

  localparam int MATRIX_ROWS = 8;
  localparam int MATRIX_COLS = 8;
  localparam int LED_INDEX_W = 6;
  localparam int IMAGE_W     = MATRIX_ROWS * MATRIX_COLS;

  localparam logic [MATRIX_ROWS-1:0] ROW_IDLE = 8'hFF;

  typedef logic [2:0]             row_t;
  typedef logic [MATRIX_COLS-1:0] col_t;
  typedef logic [IMAGE_W-1:0]     image_t;
  typedef logic [LED_INDEX_W-1:0] led_idx_t;

  typedef struct packed {
    row_t row;
    logic first;
    logic boundary;
    logic blink_phase;
  } scan_t;

  function automatic logic [MATRIX_ROWS-1:0] row_select(row_t r);
    return ~(MATRIX_ROWS'(1) << r);
  endfunction

  function automatic col_t row_slice(image_t img, row_t r);
    return img[{r, 3'b000} +: MATRIX_COLS];
  endfunction

endpackage

// File: rtl/led_matrix_scanner_if.sv
// Image handshake between the game logic and the matrix scanner.
// Master drives the image and valid; slave returns ready.
interface led_matrix_scanner_if;
  import snake_pkg::*;

  image_t in_led_array_flat;
  logic   in_frame_valid;
  logic   out_frame_ready;

  modport master (
    output in_led_array_flat,
    output in_frame_valid,
    input  out_frame_ready
  );

  modport slave (
    input  in_led_array_flat,
    input  in_frame_valid,
    output out_frame_ready
  );

endinterface

// File: rtl/led_matrix_scanner_scan_timer.sv
// Row/dwell scan counters, frame counter and blink phase.
// scan reflects the current scan position; frame_done is registered.
module scan_timer
  import snake_pkg::*;
#(
  parameter int DWELL_CYCLES = 4,
  parameter int BLINK_FRAMES = 8
) (
  input  logic  clk,
  input  logic  rst,
  output scan_t scan,
  output logic  frame_done
);

  logic [7:0] dwell;
  logic [7:0] dwell_nx;
  row_t       row;
  row_t       row_nx;
  logic [7:0] fcnt;
  logic [7:0] fcnt_nx;
  logic       phase;
  logic       phase_nx;
  logic       last_dwell;
  logic       boundary;

  assign last_dwell = dwell == 8'(DWELL_CYCLES - 1);
  assign boundary   = last_dwell
                   && row == row_t'(MATRIX_ROWS - 1);

  always_comb begin
    dwell_nx = dwell + 8'd1;
    row_nx   = row;
    fcnt_nx  = fcnt;
    phase_nx = phase;
    if (last_dwell) begin
      dwell_nx = '0;
      row_nx   = row + 3'd1;
    end
    if (boundary) begin
      if (fcnt == 8'(BLINK_FRAMES - 1)) begin
        fcnt_nx  = '0;
        phase_nx = ~phase;
      end else begin
        fcnt_nx = fcnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dwell      <= '0;
      row        <= '0;
      fcnt       <= '0;
      phase      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      dwell      <= dwell_nx;
      row        <= row_nx;
      fcnt       <= fcnt_nx;
      phase      <= phase_nx;
      frame_done <= boundary;
    end
  end

  assign scan = '{
    row:         row,
    first:       dwell == 8'd0,
    boundary:    boundary,
    blink_phase: phase
  };

endmodule

// File: rtl/led_matrix_scanner.sv
// 8x8 LED matrix row scanner with double-buffered image
// and single-LED blink; buffers swap only at frame ends.
module led_matrix_scanner
  import snake_pkg::*;
#(
  parameter int DWELL_CYCLES = 4,
  parameter int BLINK_FRAMES = 8
) (
  input  logic                   in_clka,
  input  logic                   in_restart,
  led_matrix_scanner_if.slave    frame_bus,
  input  logic                   in_blink_en,
  input  led_idx_t               in_blink_index,
  output logic [MATRIX_ROWS-1:0] out_row_cathode,
  output col_t                   out_column_anode,
  output logic                   out_frame_done
);

  scan_t  scan;
  image_t active;
  image_t pending;
  logic   pending_full;
  logic   accept;
  col_t   row_data;
  col_t   blink_mask;
  col_t   column;
  logic   blink_hit;

  scan_timer #(
    .DWELL_CYCLES (DWELL_CYCLES),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_timer (
    .clk        (in_clka),
    .rst        (in_restart),
    .scan       (scan),
    .frame_done (out_frame_done)
  );

  assign accept = frame_bus.in_frame_valid
               && !pending_full;
  assign frame_bus.out_frame_ready = !pending_full;

  // Accept never coincides with promotion: accept needs pending empty.
  always_ff @(posedge in_clka) begin
    if (in_restart) begin
      active       <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
    end else if (scan.boundary && pending_full) begin
      active       <= pending;
      pending_full <= 1'b0;
    end else if (accept) begin
      pending      <= frame_bus.in_led_array_flat;
      pending_full <= 1'b1;
    end
  end

  always_comb begin
    row_data   = row_slice(active, scan.row);
    blink_hit  = in_blink_en
              && scan.blink_phase
              && in_blink_index[5:3] == scan.row;
    blink_mask = '0;
    if (blink_hit)
      blink_mask = col_t'(1) << in_blink_index[2:0];
    // First dwell cycle of each row is blanked against ghosting.
    if (scan.first)
      column = '0;
    else
      column = row_data & ~blink_mask;
  end

  always_ff @(posedge in_clka) begin
    if (in_restart) begin
      out_row_cathode  <= ROW_IDLE;
      out_column_anode <= '0;
    end else begin
      out_row_cathode  <= row_select(scan.row);
      out_column_anode <= column;
    end
  end

endmodule
